// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - load/store request and read-data bundle for data_memory
//   RD_en  read request, sampled at the rising edge
//   WR_en  write request, sampled at the rising edge
//   mode   access size: 00 byte, 01 halfword, 11 word, 10 reserved
//   Add    base byte address
//   Rd     byte offset, effective address = Add + Rd
//   D      write data
//   Q      registered read data
interface data_memory_if;
  logic        RD_en;
  logic        WR_en;
  logic [1:0]  mode;
  logic [31:0] Add;
  logic [31:0] Rd;
  logic [31:0] D;
  logic [31:0] Q;

  modport master (output RD_en, WR_en, mode, Add, Rd, D, input Q);
  modport slave  (input RD_en, WR_en, mode, Add, Rd, D, output Q);
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable little-endian single-port data memory
//   CLK  system clock, all state changes on the rising edge
//   RST  synchronous active-high reset, clears Q only
//   bus  data_memory_if.slave: RD_en, WR_en, mode, Add, Rd, D in; Q out
//   Optional macro DMEM_SIGN_EXT_EN: byte/halfword reads sign-extend.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10
) (
  input  logic          CLK,
  input  logic          RST,
  data_memory_if.slave  bus
);

  localparam int MEM_BYTES = 4 * DEPTH_WORDS;

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rdata;

  // Only the low ADDR_W bits of the sum matter, so adding the low bits
  // alone gives the wrapped address directly.
  always_comb begin
    ea = bus.Add[ADDR_W-1:0] + bus.Rd[ADDR_W-1:0];
    case (bus.mode)
      2'b01:   a0 = {ea[ADDR_W-1:1], 1'b0};
      2'b11:   a0 = {ea[ADDR_W-1:2], 2'b00};
      default: a0 = ea;
    endcase
    // a0 is aligned for multi-byte accesses, so OR selects the lane
    // without a carry into the word address.
    a1 = a0 | ADDR_W'(1);
    a2 = a0 | ADDR_W'(2);
    a3 = a0 | ADDR_W'(3);
  end

  always_comb begin
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    rdata = 32'h0;
    case (bus.mode)
`ifdef DMEM_SIGN_EXT_EN
      2'b00:   rdata = {{24{b0[7]}}, b0};
      2'b01:   rdata = {{16{b1[7]}}, b1, b0};
`else
      2'b00:   rdata = {24'h0, b0};
      2'b01:   rdata = {16'h0, b1, b0};
`endif
      2'b11:   rdata = {b3, b2, b1, b0};
      default: rdata = 32'h0;
    endcase
  end

  // Contents survive reset; the reset cycle only blocks the write.
  always_ff @(posedge CLK) begin
    if (!RST && bus.WR_en) begin
      case (bus.mode)
        2'b00: mem[a0] <= bus.D[7:0];
        2'b01: begin
          mem[a0] <= bus.D[7:0];
          mem[a1] <= bus.D[15:8];
        end
        2'b11: begin
          mem[a0] <= bus.D[7:0];
          mem[a1] <= bus.D[15:8];
          mem[a2] <= bus.D[23:16];
          mem[a3] <= bus.D[31:24];
        end
        default: ;
      endcase
    end
  end

  // rdata is sampled from the pre-edge array, giving read-before-write
  // when RD_en and WR_en coincide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.Q <= 32'h0;
    end else if (bus.RD_en) begin
      bus.Q <= rdata;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory
module tb_data_memory;

  localparam int DEPTH_WORDS = 256;
  localparam int MEM_BYTES   = 4 * DEPTH_WORDS;
`ifdef DMEM_SIGN_EXT_EN
  localparam bit SX = 1'b1;
`else
  localparam bit SX = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(10)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [7:0]  model [MEM_BYTES];
  bit          known [MEM_BYTES];
  logic [31:0] exp_q;
  bit          exp_known = 1'b0;

  function automatic int unsigned size_of(input logic [1:0] m);
    case (m)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_read(input logic [1:0] m, input int unsigned ea,
                            output logic [31:0] v, output bit ok);
    int unsigned n, base;
    n = size_of(m);
    v = 32'h0;
    ok = 1'b1;
    if (n != 0) begin
      base = ea - (ea % n);
      for (int i = 0; i < n; i++) begin
        v = v + (32'(model[base + i]) << (8 * i));
        if (!known[base + i]) ok = 1'b0;
      end
      if (SX && n == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
      if (SX && n == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
  endtask

  task automatic model_write(input logic [1:0] m, input int unsigned ea,
                             input logic [31:0] d);
    int unsigned n, base;
    logic [31:0] t;
    n = size_of(m);
    if (n != 0) begin
      base = ea - (ea % n);
      t = d;
      for (int i = 0; i < n; i++) begin
        model[base + i] = t[7:0];
        known[base + i] = 1'b1;
        t = t >> 8;
      end
    end
  endtask

  // One clock: drive, step the model, then compare Q one time unit after the edge.
  task automatic step(input string tag, input bit rst, input bit rd, input bit wr,
                      input logic [1:0] m, input logic [31:0] add,
                      input logic [31:0] off, input logic [31:0] d);
    logic [31:0] sum, rv;
    int unsigned ea;
    bit rk;
    RST = rst;
    bus.RD_en = rd;
    bus.WR_en = wr;
    bus.mode = m;
    bus.Add = add;
    bus.Rd = off;
    bus.D = d;
    sum = add + off;
    ea = sum % MEM_BYTES;
    model_read(m, ea, rv, rk);
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_q = 32'h0;
      exp_known = 1'b1;
    end else begin
      if (rd) begin
        exp_q = rv;
        exp_known = rk;
      end
      if (wr) model_write(m, ea, d);
    end
    if (exp_known) begin
      compared++;
      assert (bus.Q === exp_q) else begin
        mismatched++;
        $error("FAIL %s: Q=%h expected %h", tag, bus.Q, exp_q);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] want);
    compared++;
    assert (bus.Q === want) else begin
      mismatched++;
      $error("FAIL %s: Q=%h expected %h", tag, bus.Q, want);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      model[i] = 8'h0;
      known[i] = 1'b0;
    end
    bus.RD_en = 1'b0;
    bus.WR_en = 1'b0;
    bus.mode = 2'b00;
    bus.Add = 32'h0;
    bus.Rd = 32'h0;
    bus.D = 32'h0;
    @(posedge CLK);
    #1;

    step("reset", 1, 0, 0, 2'b00, 0, 0, 0);
    chk("reset_q", 32'h0);

    step("byte_wr", 0, 0, 1, 2'b00, 0, 0, 32'h000000AA);
    step("byte_rd", 0, 1, 0, 2'b00, 0, 0, 0);
    chk("byte_rd_q", SX ? 32'hFFFFFFAA : 32'h000000AA);

    step("half_wr", 0, 0, 1, 2'b01, 0, 0, 32'h00001234);
    step("half_rd", 0, 1, 0, 2'b01, 0, 0, 0);
    chk("half_rd_q", 32'h00001234);

    step("word_wr", 0, 0, 1, 2'b11, 0, 0, 32'hDEADBEEF);
    step("word_rd", 0, 1, 0, 2'b11, 0, 0, 0);
    chk("word_rd_q", 32'hDEADBEEF);

    step("lane_wr", 0, 0, 1, 2'b00, 1, 0, 32'h00000055);
    step("lane_word_rd", 0, 1, 0, 2'b11, 0, 0, 0);
    chk("lane_word_q", 32'hDEAD55EF);
    step("lane_byte_rd", 0, 1, 0, 2'b00, 0, 3, 0);
    chk("lane_byte_q", SX ? 32'hFFFFFFDE : 32'h000000DE);

    step("align_rd", 0, 1, 0, 2'b11, 2, 0, 0);
    chk("align_q", 32'hDEAD55EF);

    step("wrap_wr", 0, 0, 1, 2'b11, MEM_BYTES, 0, 32'h11223344);
    step("wrap_rd", 0, 1, 0, 2'b11, 0, 0, 0);
    chk("wrap_q", 32'h11223344);

    step("sim_prep", 0, 0, 1, 2'b11, 0, 0, 32'hDEADBEEF);
    step("sim_rw", 0, 1, 1, 2'b11, 0, 0, 32'hCAFEF00D);
    chk("sim_old_q", 32'hDEADBEEF);
    step("sim_rd", 0, 1, 0, 2'b11, 0, 0, 0);
    chk("sim_new_q", 32'hCAFEF00D);

    step("rst_rw", 1, 1, 1, 2'b11, 0, 0, 32'h0BADF00D);
    chk("rst_q", 32'h0);
    step("hold_res", 0, 0, 1, 2'b10, 0, 0, 32'hFFFFFFFF);
    chk("hold_q", 32'h0);
    step("after_rst_rd", 0, 1, 0, 2'b11, 0, 0, 0);
    chk("mem_kept_q", 32'hCAFEF00D);
    step("res_rd", 0, 1, 0, 2'b10, 0, 0, 0);
    chk("res_rd_q", 32'h0);

    for (int i = 0; i < DEPTH_WORDS; i++) begin
      step("fill", 0, 0, 1, 2'b11, 32'(4 * i), 0, $urandom);
    end
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
    end
    RST = 1'b0;
    bus.RD_en = 1'b0;
    bus.WR_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
